i232c_rx: RTL and testbench
===========================

I232C_RX -- requirements
Module: i232c_rx

Interface
REQ-001 The block SHALL have parameter WTIME, default 16'd620, giving the clock cycles per serial bit (71.4 MHz / 115200 baud).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port xrst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port enable, input, 1 bit: reception permitted while high.
REQ-005 The block SHALL have port rx, input, 1 bit: asynchronous RS-232C serial line, idle high.
REQ-006 The block SHALL have port data, output, 8 bits: last correctly framed received byte.
REQ-007 The block SHALL have port changed, output, 1 bit: one-cycle pulse marking a new byte on data.
REQ-008 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.

Function
REQ-009 The block SHALL pass rx through a two-flop synchronizer; all decisions use the synchronized value (rx_s), adding 2 cycles of input latency.
REQ-010 The block SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH with a 16-bit cycle counter and 3-bit bit index.
REQ-011 In IDLE with enable=1, a 1->0 transition of rx_s SHALL enter START and clear the counter; with enable=0, IDLE SHALL be held.
REQ-012 START SHALL wait WTIME/2 cycles (integer division), then resample: rx_s=0 -> DATA with counter cleared; rx_s=1 -> IDLE (glitch rejected, no output change).
REQ-013 DATA SHALL sample rx_s every WTIME cycles, 8 samples, LSB first, into an internal shift register; after the 8th sample it SHALL enter STOP.
REQ-014 STOP SHALL sample rx_s after WTIME cycles: 1 -> load data with the shift register, pulse changed for exactly one cycle, return to IDLE; 0 -> pulse frame_err for one cycle, leave data unchanged, enter WAIT_HIGH.
REQ-015 WAIT_HIGH SHALL return to IDLE only once rx_s=1, so a break condition never yields a byte.
REQ-016 data and changed SHALL be registered and update on the same clock edge; data SHALL hold its value until the next valid frame.
REQ-017 changed and frame_err SHALL never be asserted in the same cycle.
REQ-018 Deasserting enable in any state other than IDLE SHALL abort the frame and return to IDLE next cycle, with no pulse and data unchanged.
REQ-019 A start edge arriving in the cycle the block returns to IDLE SHALL be detected, so back-to-back frames with one stop bit are received without loss.
REQ-020 Counter arithmetic SHALL be unsigned 16-bit; WTIME values from 4 to 65535 SHALL be supported.

Reset
REQ-021 While xrst=0 the block SHALL be in IDLE, with both synchronizer flops=1, data=8'h00, changed=0, frame_err=0, and counter and bit index=0.
REQ-022 Reset asserted mid-frame SHALL discard the partial byte immediately; after release a frame SHALL be received only from a fresh start edge.

Verification (WTIME=16 for simulation)
REQ-023 Frame for 8'hA5 with 16-cycle bits -> changed pulses once for one cycle, data=8'hA5 about 154-160 cycles after the start edge.
REQ-024 Two back-to-back frames 8'h00 then 8'hFF -> two changed pulses, data 8'h00 then 8'hFF, frame_err never set.
REQ-025 rx low pulse of 4 cycles in idle -> no changed, no frame_err, state returns to IDLE, data unchanged.
REQ-026 Frame 8'h3C with the stop bit held low for 40 cycles -> one frame_err pulse, data keeps its previous value, next valid frame 8'h11 received correctly.
REQ-027 enable=0 during a full frame 8'h55 -> no changed; enable dropped mid-frame -> abort, no outputs.
REQ-028 xrst pulsed low during data bit 3 of a frame -> outputs reset to zero values, no changed for that frame.

Source files
------------

// File: rtl/i232c_rx.sv
// RS-232C receiver: 8N1 framing, two-flop input synchronizer, mid-bit sampling.
// Emits a one-cycle changed pulse with the new byte, or frame_err on a bad stop bit.
module i232c_rx #(
  parameter logic [15:0] WTIME = 16'd620
) (
  input  logic       clk,
  input  logic       xrst,
  input  logic       enable,
  input  logic       rx,
  output logic [7:0] data,
  output logic       changed,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  localparam logic [15:0] HALF_M1  = (WTIME >> 1) - 16'd1;
  localparam logic [15:0] WTIME_M1 = WTIME - 16'd1;

  state_t      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_rx_d;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_changed;
  logic        r_frame_err;

  logic        w_rx_s;
  logic        w_fall;

  assign w_rx_s = r_sync2;
  // r_rx_d tracks rx_s in every state, so a fall right as IDLE is re-entered is still seen.
  assign w_fall = r_rx_d & ~w_rx_s;

  assign data      = r_data;
  assign changed   = r_changed;
  assign frame_err = r_frame_err;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_state     <= S_IDLE;
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_rx_d      <= 1'b1;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_changed   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1     <= rx;
      r_sync2     <= r_sync1;
      r_rx_d      <= r_sync2;
      r_changed   <= 1'b0;
      r_frame_err <= 1'b0;

      if (!enable && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_bit   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (enable && w_fall) begin
              r_state <= S_START;
              r_cnt   <= '0;
            end
          end

          S_START: begin
            if (r_cnt == HALF_M1) begin
              r_cnt <= '0;
              r_bit <= '0;
              r_state <= w_rx_s ? S_IDLE : S_DATA;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end

          S_DATA: begin
            if (r_cnt == WTIME_M1) begin
              r_cnt   <= '0;
              r_shift <= {w_rx_s, r_shift[7:1]};
              if (r_bit == 3'd7) begin
                r_bit   <= '0;
                r_state <= S_STOP;
              end else begin
                r_bit <= r_bit + 3'd1;
              end
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end

          S_STOP: begin
            if (r_cnt == WTIME_M1) begin
              r_cnt <= '0;
              if (w_rx_s) begin
                r_data    <= r_shift;
                r_changed <= 1'b1;
                r_state   <= S_IDLE;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= S_WAIT_HIGH;
              end
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end

          S_WAIT_HIGH: begin
            if (w_rx_s) r_state <= S_IDLE;
          end

          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i232c_rx.sv
// Scoreboard bench for i232c_rx with 16-cycle bits: expected bytes queued at
// transmit time, popped and compared whenever the receiver pulses changed.
module tb_i232c_rx;

  localparam int unsigned BIT = 16;

  logic       clk;
  logic       xrst;
  logic       enable;
  logic       rx;
  logic [7:0] data;
  logic       changed;
  logic       frame_err;

  i232c_rx #(.WTIME(16'd16)) dut (
    .clk      (clk),
    .xrst     (xrst),
    .enable   (enable),
    .rx       (rx),
    .data     (data),
    .changed  (changed),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned t_start  = 0;
  int unsigned n_chg    = 0;
  int          ferr_pending = 0;
  bit          lat_arm  = 1'b0;
  logic        prev_chg = 1'b0;
  logic        prev_ferr = 1'b0;
  logic [7:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every changed pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (changed) begin
      n_chg++;
      check("chg_width", 32'(prev_chg), 32'd0);
      check("chg_excl_ferr", 32'(frame_err), 32'd0);
      check("chg_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("data", 32'(data), 32'(exp_q.pop_front()));
      if (lat_arm) begin
        lat_arm = 1'b0;
        check("latency_in_range", 32'((cyc - t_start >= 154) && (cyc - t_start <= 160)), 32'd1);
      end
    end
    if (frame_err) begin
      check("ferr_width", 32'(prev_ferr), 32'd0);
      check("ferr_expected", 32'(ferr_pending > 0), 32'd1);
      ferr_pending--;
    end
    prev_chg  = changed;
    prev_ferr = frame_err;
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // stop_low > 0 holds the stop bit low that many cycles before returning high.
  task automatic send_frame(input logic [7:0] b, input int unsigned stop_low);
    @(negedge clk);
    rx = 1'b0;
    t_start = cyc;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(BIT);
    end
    if (stop_low > 0) begin
      rx = 1'b0;
      idle(stop_low);
    end
    rx = 1'b1;
    idle(BIT - 1);
  endtask

  initial begin
    xrst = 1'b0;
    enable = 1'b1;
    rx = 1'b1;
    idle(4);
    check("rst_data", 32'(data), 32'h00);
    check("rst_changed", 32'(changed), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    xrst = 1'b1;
    idle(10);

    // single frame with latency measurement
    exp_q.push_back(8'hA5);
    lat_arm = 1'b1;
    send_frame(8'hA5, 0);
    idle(20);
    check("a5_held", 32'(data), 32'hA5);

    // back-to-back frames, one stop bit
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 0);
    send_frame(8'hFF, 0);
    idle(20);
    check("b2b_last", 32'(data), 32'hFF);

    // start-bit glitch
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(40);
    check("glitch_data", 32'(data), 32'hFF);

    // broken stop bit then recovery
    ferr_pending++;
    send_frame(8'h3C, 40);
    idle(10);
    check("ferr_data_kept", 32'(data), 32'hFF);
    check("ferr_seen", 32'(ferr_pending), 32'd0);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 0);
    idle(20);
    check("after_ferr", 32'(data), 32'h11);

    // disabled for a whole frame
    enable = 1'b0;
    send_frame(8'h55, 0);
    idle(10);
    enable = 1'b1;
    idle(10);
    check("disabled_data", 32'(data), 32'h11);

    // enable dropped mid-frame, restored only once the line is idle
    fork
      send_frame(8'h77, 0);
      begin
        idle(BIT * 5);
        enable = 1'b0;
      end
    join
    idle(10);
    enable = 1'b1;
    idle(10);
    check("abort_data", 32'(data), 32'h11);

    // reset during data bit 3, released while the line is high
    fork
      send_frame(8'hF5, 0);
      begin
        idle(BIT * 4 + 8);
        xrst = 1'b0;
        idle(2);
        check("midrst_data", 32'(data), 32'h00);
        check("midrst_changed", 32'(changed), 32'd0);
        idle(BIT - 2);
        xrst = 1'b1;
      end
    join
    idle(20);
    check("post_rst_data", 32'(data), 32'h00);

    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 0);
    idle(20);
    check("recover_data", 32'(data), 32'h5A);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("ferr_balance", 32'(ferr_pending), 32'd0);
    check("changed_total", 32'(n_chg), 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
